// File: rtl/clk_ratio_detector_if.sv
// Signal bundle between a divided-clock source and clk_ratio_detector.
// master: the side that produces divClk and observes the measurement results.
// slave : the detector itself.
interface clk_ratio_detector_if #(
  parameter int CNT_W = 13
);
  logic             divClk;
  logic [3:0]       nOut;
  logic             locked;
  logic [CNT_W-1:0] periodOut;
  logic             measErr;
  logic             timeout;

  modport master (
    output divClk,
    input  nOut, locked, periodOut, measErr, timeout
  );

  modport slave (
    input  divClk,
    output nOut, locked, periodOut, measErr, timeout
  );
endinterface

// File: rtl/clk_ratio_detector.sv
// clk_ratio_detector: recovers the exponent n of a divided clock
// divClk = inClk / 2^n by counting inClk cycles between rising edges of the
// synchronised divClk. Locks after LOCK_COUNT consecutive equal legal periods,
// pulses measErr on malformed periods and raises timeout on dropout.
//
// Optional feature, enabled by defining CLK_RATIO_DUTY_CHECK_EN: the high
// time of each divClk period is also counted and a period whose high time is
// not exactly half of it is rejected as illegal.
module clk_ratio_detector #(
  parameter int MAX_N      = 11,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 13,
  parameter int TIMEOUT    = 4096
) (
  input  logic inClk,
  input  logic reset,
  clk_ratio_detector_if.slave bus
);

  localparam int               MW        = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LOCK_C    = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } stateT;

  // Synchroniser / edge detector
  logic sync1, sync2, prev;
  logic edgeDet;

  // Period measurement
  logic [CNT_W-1:0] periodCnt;
  logic             cntAtTimeout;
  logic [MAX_N:1]   powHit;
  logic [3:0]       candN;
  logic             dutyOk;
  logic             measLegal;

  // FSM and output registers
  stateT            stateReg, stateNext;
  logic [MW-1:0]    matchCntReg, matchCntNext;
  logic [3:0]       lastNReg, lastNNext;
  logic [3:0]       nOutReg, nOutNext;
  logic             lockedReg, lockedNext;
  logic             timeoutReg, timeoutNext;
  logic             measErrReg, measErrNext;
  logic [CNT_W-1:0] periodOutReg, periodOutNext;

  // Two-flop synchroniser followed by a delay flop for rising-edge detection
  always_ff @(posedge inClk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= bus.divClk;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edgeDet = sync2 & ~prev;

  // Period counter: restarts at 1 on every edge, saturates at TIMEOUT so the
  // value seen on an edge is exactly the number of cycles since the last one
  always_ff @(posedge inClk or posedge reset) begin
    if (reset) begin
      periodCnt <= '0;
    end else if (edgeDet) begin
      periodCnt <= CNT_W'(1);
    end else if (!cntAtTimeout) begin
      periodCnt <= periodCnt + CNT_W'(1);
    end
  end

  assign cntAtTimeout = (periodCnt == TIMEOUT_C);

  // One comparator per recognised exponent; a legal period hits exactly one.
  // Covering only 2^1..2^MAX_N also rejects 1, non-powers and oversize values.
  generate
    for (genvar gi = 1; gi <= MAX_N; gi++) begin : gPow
      assign powHit[gi] = (periodCnt == CNT_W'(1 << gi));
    end
  endgenerate

  // Encode the hit position as the candidate exponent
  always_comb begin
    candN = '0;
    for (int i = 1; i <= MAX_N; i++) begin
      if (powHit[i]) candN = 4'(i);
    end
  end

`ifdef CLK_RATIO_DUTY_CHECK_EN
  logic [CNT_W-1:0] highCnt;

  // High-time counter: starts at 1 on the edge cycle and counts while the
  // synchronised clock stays high, so at the next edge it holds the high time
  always_ff @(posedge inClk or posedge reset) begin
    if (reset) begin
      highCnt <= '0;
    end else if (edgeDet) begin
      highCnt <= CNT_W'(1);
    end else if (sync2 && prev && (highCnt != {CNT_W{1'b1}})) begin
      highCnt <= highCnt + CNT_W'(1);
    end
  end

  assign dutyOk = (highCnt == (periodCnt >> 1));
`else
  assign dutyOk = 1'b1;
`endif

  assign measLegal = (|powHit) & dutyOk;

  // FSM state and result registers
  always_ff @(posedge inClk or posedge reset) begin
    if (reset) begin
      stateReg     <= IDLE;
      matchCntReg  <= '0;
      lastNReg     <= '0;
      nOutReg      <= '0;
      lockedReg    <= 1'b0;
      timeoutReg   <= 1'b0;
      measErrReg   <= 1'b0;
      periodOutReg <= '0;
    end else begin
      stateReg     <= stateNext;
      matchCntReg  <= matchCntNext;
      lastNReg     <= lastNNext;
      nOutReg      <= nOutNext;
      lockedReg    <= lockedNext;
      timeoutReg   <= timeoutNext;
      measErrReg   <= measErrNext;
      periodOutReg <= periodOutNext;
    end
  end

  // Next-state logic: every edge outside IDLE is one measurement
  always_comb begin
    stateNext     = stateReg;
    matchCntNext  = matchCntReg;
    lastNNext     = lastNReg;
    nOutNext      = nOutReg;
    lockedNext    = lockedReg;
    timeoutNext   = timeoutReg;
    measErrNext   = 1'b0;
    periodOutNext = periodOutReg;

    case (stateReg)
      IDLE: begin
        // First edge only gives a reference point; nothing is measured
        if (edgeDet) begin
          timeoutNext = 1'b0;
          stateNext   = MEASURE;
        end
      end

      MEASURE, LOCKED: begin
        if (edgeDet) begin
          // An edge wins over a simultaneous timeout; m = TIMEOUT is illegal
          periodOutNext = periodCnt;
          if (!measLegal) begin
            measErrNext  = 1'b1;
            matchCntNext = '0;
            lockedNext   = 1'b0;
            stateNext    = MEASURE;
          end else begin
            if (candN == lastNReg) begin
              if (matchCntReg != LOCK_C) matchCntNext = matchCntReg + MW'(1);
            end else begin
              // New rate: restart the run, keep the stale nOut until relock
              lastNNext    = candN;
              matchCntNext = MW'(1);
              lockedNext   = 1'b0;
              stateNext    = MEASURE;
            end
            if (matchCntNext == LOCK_C) begin
              nOutNext   = lastNNext;
              lockedNext = 1'b1;
              stateNext  = LOCKED;
            end
          end
        end else if (cntAtTimeout) begin
          timeoutNext  = 1'b1;
          lockedNext   = 1'b0;
          matchCntNext = '0;
          stateNext    = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  assign bus.nOut      = nOutReg;
  assign bus.locked    = lockedReg;
  assign bus.periodOut = periodOutReg;
  assign bus.measErr   = measErrReg;
  assign bus.timeout   = timeoutReg;

endmodule
